bit_stream_serializer: RTL and testbench

- Upstream feeder for the team's serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single-bit stream, `x`, which drives the detector's `x` input directly.
- Supports back-to-back words with no idle gap, so multi-word test patterns reach the detector as one continuous bitstream.

---
 rtl/serializer_pkg.sv | 20 ++
 rtl/serializer_bit_counter.sv | 37 +++
 rtl/bit_stream_serializer.sv | 90 +++++++++
 tb/tb_bit_stream_serializer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the bit-stream serializer.
// Optional parity bit is enabled by defining SERIALIZER_PARITY_EN.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int WORDS_SENT_W = 16;

  // Counter must hold indices 0..WIDTH (WIDTH is the parity slot).
  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int COUNT_W       = count_w(DEFAULT_WIDTH);

endpackage

// File: rtl/serializer_bit_counter.sv
// Bit-position counter with clear, increment and last-bit compare.
// Last index is WIDTH when SERIALIZER_PARITY_EN is defined, else WIDTH-1.
module serializer_bit_counter
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = count_w(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_bit_o
);

`ifdef SERIALIZER_PARITY_EN
  localparam int LAST_IDX = WIDTH;
`else
  localparam int LAST_IDX = WIDTH - 1;
`endif

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign last_bit_o = (cnt_q == CW'(LAST_IDX));

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder for the sequence detector, with gapless back-to-back words.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_stream_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    x,
  output logic                    x_valid,
  output logic                    word_done,
  output logic [WORDS_SENT_W-1:0] words_sent
);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        shreg_q, shreg_d, shreg_nxt;
  logic [WORDS_SENT_W-1:0] ws_q, ws_d;
  logic                    shifting, last_bit, accept, data_bit, bit_out;

  assign shifting = (state_q == SHIFT);
  assign in_ready = rst && (!shifting || last_bit);
  assign accept   = in_valid && in_ready;
  assign data_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_nxt = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  serializer_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept || (shifting && last_bit)),
    .inc_i     (shifting),
    .last_bit_o(last_bit)
  );

`ifdef SERIALIZER_PARITY_EN
  logic par_q, par_d;

  // The parity slot is always the last-bit cycle, so no separate index compare.
  assign bit_out = last_bit ? par_q : data_bit;

  always_comb begin
    par_d = par_q;
    if (accept) par_d = ^in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
  end
`else
  assign bit_out = data_bit;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    ws_d    = ws_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = in_data;
    end else if (shifting) begin
      shreg_d = shreg_nxt;
      if (last_bit) state_d = IDLE;
    end
    if (shifting && last_bit) ws_d = ws_q + WORDS_SENT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      ws_q    <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      ws_q    <= ws_d;
    end
  end

  assign x          = shifting ? bit_out : IDLE_LEVEL;
  assign x_valid    = shifting;
  assign word_done  = shifting && last_bit;
  assign words_sent = ws_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: one MSB-first and one LSB-first instance
// driven from scenario tasks and checked against a per-cycle bit-stream model.
module tb_bit_stream_serializer;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif
  localparam logic IDLE = 1'b0;

  logic        clk, rst;
  logic        iv_m, iv_l;
  logic [W-1:0] id_m, id_l;
  logic        rdy_m, x_m, xv_m, wd_m;
  logic        rdy_l, x_l, xv_l, wd_l;
  logic [15:0] ws_m, ws_l;

  int n_cmp, n_bad;
  int exp_ws_m, exp_ws_l;
  logic [W-1:0] words[$];

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_data(id_m), .in_valid(iv_m), .in_ready(rdy_m),
    .x(x_m), .x_valid(xv_m), .word_done(wd_m), .words_sent(ws_m)
  );

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(id_l), .in_valid(iv_l), .in_ready(rdy_l),
    .x(x_l), .x_valid(xv_l), .word_done(wd_l), .words_sent(ws_l)
  );

  always #5 clk = ~clk;

  // Position p of a word on the wire: data bits in the chosen order, then parity.
  function automatic logic exp_bit(input logic [W-1:0] w, input int p, input bit msb);
    if (p >= W) return ^w;
    return msb ? w[W-1-p] : w[p];
  endfunction

  task automatic drive(input bit lsb, input logic v, input logic [W-1:0] d);
    iv_m = 1'b0; iv_l = 1'b0;
    if (lsb) begin iv_l = v; id_l = d; end
    else     begin iv_m = v; id_m = d; end
  endtask

  // Words in 'words' are offered back to back with in_valid held; each is held
  // until its acceptance cycle (cycle 0, then the last bit of the previous word).
  task automatic run_stream(input string tag, input bit lsb);
    int n, idx, k, p;
    logic e_x, e_xv, e_wd, e_rdy, o_x, o_xv, o_wd, o_rdy;
    int o_ws;
    n = words.size();
    for (int c = 0; c <= n * L + 1; c++) begin
      idx = (c == 0) ? 0 : 1 + (c - 1) / L;
      if (idx < n) drive(lsb, 1'b1, words[idx]);
      else         drive(lsb, 1'b0, W'($urandom));
      @(negedge clk);
      if (c >= 1 && c <= n * L) begin
        k = (c - 1) / L; p = (c - 1) % L;
        e_xv = 1'b1; e_x = exp_bit(words[k], p, !lsb); e_wd = (p == L - 1); e_rdy = e_wd;
      end else begin
        e_xv = 1'b0; e_x = IDLE; e_wd = 1'b0; e_rdy = 1'b1;
      end
      o_x = lsb ? x_l : x_m;     o_xv = lsb ? xv_l : xv_m;
      o_wd = lsb ? wd_l : wd_m;  o_rdy = lsb ? rdy_l : rdy_m;
      n_cmp++; if (o_xv !== e_xv) begin n_bad++; $display("FAIL %s x_valid cyc=%0d got=%b exp=%b", tag, c, o_xv, e_xv); end
      n_cmp++; if (o_x !== e_x) begin n_bad++; $display("FAIL %s x cyc=%0d got=%b exp=%b", tag, c, o_x, e_x); end
      n_cmp++; if (o_wd !== e_wd) begin n_bad++; $display("FAIL %s word_done cyc=%0d got=%b exp=%b", tag, c, o_wd, e_wd); end
      n_cmp++; if (o_rdy !== e_rdy) begin n_bad++; $display("FAIL %s in_ready cyc=%0d got=%b exp=%b", tag, c, o_rdy, e_rdy); end
      @(posedge clk); #1;
    end
    if (lsb) exp_ws_l += n; else exp_ws_m += n;
    o_ws = lsb ? int'(ws_l) : int'(ws_m);
    n_cmp++;
    if (o_ws != ((lsb ? exp_ws_l : exp_ws_m) & 16'hFFFF)) begin
      n_bad++; $display("FAIL %s words_sent got=%0d exp=%0d", tag, o_ws, lsb ? exp_ws_l : exp_ws_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; drive(1'b0, 1'b1, 8'hC3); iv_l = 1'b1; id_l = 8'h3C;
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({rdy_m, rdy_l} !== 2'b00) begin n_bad++; $display("FAIL reset in_ready got=%b exp=00", {rdy_m, rdy_l}); end
    n_cmp++; if ({xv_m, xv_l, wd_m, wd_l} !== 4'b0) begin n_bad++; $display("FAIL reset xv/wd got=%b exp=0000", {xv_m, xv_l, wd_m, wd_l}); end
    n_cmp++; if ({x_m, x_l} !== {IDLE, IDLE}) begin n_bad++; $display("FAIL reset x got=%b exp=%b%b", {x_m, x_l}, IDLE, IDLE); end
    n_cmp++; if ({ws_m, ws_l} !== 32'h0) begin n_bad++; $display("FAIL reset words_sent got=%h exp=0", {ws_m, ws_l}); end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00); rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({rdy_m, rdy_l, xv_m, xv_l} !== 4'b1100) begin n_bad++; $display("FAIL post_reset rdy/xv got=%b exp=1100", {rdy_m, rdy_l, xv_m, xv_l}); end
    @(posedge clk); #1;
    exp_ws_m = 0; exp_ws_l = 0;
  endtask

  task automatic test_single_msb();
    words = {8'h36}; run_stream("single_36", 1'b0);
  endtask

  task automatic test_back_to_back();
    words = {8'hA5, 8'h3C}; run_stream("b2b_A5_3C", 1'b0);
  endtask

  task automatic test_lsb_first();
    words = {8'h01}; run_stream("lsb_01", 1'b1);
  endtask

  task automatic test_hold_while_busy();
    words = {W'($urandom), 8'h5A}; run_stream("hold_5A", 1'b0);
  endtask

  task automatic test_parity_word();
    words = {8'h07}; run_stream("word_07", 1'b0);
  endtask

  task automatic test_reset_mid_word();
    drive(1'b0, 1'b1, 8'hFF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({xv_m, x_m} !== 2'b11) begin n_bad++; $display("FAIL rst_mid bit%0d got=%b exp=11", c, {xv_m, x_m}); end
      @(posedge clk); #1;
    end
    rst = 1'b0; drive(1'b0, 1'b1, 8'hAA);
    @(negedge clk);
    n_cmp++; if (rdy_m !== 1'b0) begin n_bad++; $display("FAIL rst_mid in_ready got=%b exp=0", rdy_m); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({xv_m, x_m, wd_m} !== {1'b0, IDLE, 1'b0}) begin n_bad++; $display("FAIL rst_mid drop got=%b exp=0%b0", {xv_m, x_m, wd_m}, IDLE); end
    n_cmp++; if (ws_m !== 16'h0) begin n_bad++; $display("FAIL rst_mid words_sent got=%0d exp=0", ws_m); end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00); rst = 1'b1;
    exp_ws_m = 0; exp_ws_l = 0;
    for (int c = 0; c < L + 2; c++) begin
      @(negedge clk);
      n_cmp++; if ({rdy_m, xv_m, x_m} !== {1'b1, 1'b0, IDLE}) begin n_bad++; $display("FAIL rst_mid leftover cyc=%0d got=%b exp=10%b", c, {rdy_m, xv_m, x_m}, IDLE); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    bit lsb;
    int n, gap;
    repeat (8) begin
      lsb = bit'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      words = {};
      repeat (n) words.push_back(W'($urandom));
      run_stream(lsb ? "rand_lsb" : "rand_msb", lsb);
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        n_cmp++; if ({xv_m, xv_l} !== 2'b00) begin n_bad++; $display("FAIL rand_gap x_valid got=%b exp=00", {xv_m, xv_l}); end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0;
    iv_m = 1'b0; iv_l = 1'b0; id_m = '0; id_l = '0;
    n_cmp = 0; n_bad = 0; exp_ws_m = 0; exp_ws_l = 0;
    @(posedge clk); #1;
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_lsb_first();
    test_hold_while_busy();
    test_parity_word();
    test_reset_mid_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
